// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a prefetch FIFO: one memory request in flight,
// buffered {pc, instruction} entries handed to decode over valid/ready.
module fetch_queue #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned INST_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned PC_STEP    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  jump_i,
   input  logic [ADDR_WIDTH-1:0] jump_pc_i,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_done_i,
   input  logic [INST_WIDTH-1:0] mem_data_i,
   output logic                  inst_valid_o,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   input  logic                  inst_ready_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DROP
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
   logic                   mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   push;
   logic                   pop;

   logic [INST_WIDTH-1:0]  inst_buf_q [DEPTH];
   logic [ADDR_WIDTH-1:0]  pc_buf_q   [DEPTH];

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      push       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (jump_i) begin
               fetch_pc_d = jump_pc_i;
            end else if (count_q < CNT_W'(DEPTH)) begin
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_done_i) begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
               if (jump_i) begin
                  fetch_pc_d = jump_pc_i;
               end else begin
                  push       = 1'b1;
                  fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
               end
            end else if (jump_i) begin
               fetch_pc_d = jump_pc_i;
               state_d    = S_DROP;
            end
         end
         S_DROP: begin
            // The stale request must still complete before a new one may start.
            if (jump_i) begin
               fetch_pc_d = jump_pc_i;
            end
            if (mem_done_i) begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      pop     = (count_q != '0) && inst_ready_i && !jump_i;

      if (jump_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            tail_d = tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Entry storage needs no reset; it is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_buf_q[tail_q] <= mem_data_i;
         pc_buf_q[tail_q]   <= fetch_pc_q;
      end
   end

   assign mem_req_o    = mem_req_q;
   assign mem_addr_o   = mem_addr_q;
   assign inst_valid_o = (count_q != '0);
   assign inst_o       = inst_valid_o ? inst_buf_q[head_q] : '0;
   assign pc_o         = inst_valid_o ? pc_buf_q[head_q] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a latency-programmable memory model
// feeds a scoreboard of expected {pc, instruction} entries popped by decode.
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic        jump_i;
   logic [31:0] jump_pc_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_done_i;
   logic [31:0] mem_data_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        inst_ready_i;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t      sb[$];
   int          tests;
   int          fails;
   int          lat;
   int          age;
   int          req_count;
   int          push_count;
   logic [31:0] exp_pc;
   logic        prev_req;
   logic        dropping;
   logic        ready;
   logic        pop_on_done;

   fetch_queue #(
      .ADDR_WIDTH(32),
      .INST_WIDTH(32),
      .DEPTH(4),
      .RESET_PC(32'h0),
      .PC_STEP(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .jump_i(jump_i),
      .jump_pc_i(jump_pc_i),
      .mem_req_o(mem_req_o),
      .mem_addr_o(mem_addr_o),
      .mem_done_i(mem_done_i),
      .mem_data_i(mem_data_i),
      .inst_valid_o(inst_valid_o),
      .inst_o(inst_o),
      .pc_o(pc_o),
      .inst_ready_i(inst_ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeoutFail(input string tag);
      tests++;
      fails++;
      $display("[TB] FAIL %s observed=timeout expected=event", tag);
   endtask

   // One clock of stimulus: check outputs, run the memory model, update the scoreboard.
   task automatic applyStimulus(input logic jmp, input logic [31:0] jpc);
      logic   done;
      logic   rdy;
      entry_t e;
      @(negedge clk);
      checkOutput("inst_valid", 32'(inst_valid_o), 32'(sb.size() != 0));
      if (sb.size() == 0) begin
         checkOutput("inst_empty", inst_o, 32'h0);
         checkOutput("pc_empty", pc_o, 32'h0);
      end
      if (mem_req_o && !prev_req) begin
         checkOutput("req_addr", mem_addr_o, exp_pc);
         req_count++;
      end
      prev_req = mem_req_o;

      done = 1'b0;
      if (mem_req_o) begin
         age++;
         if (age >= lat) begin
            done = 1'b1;
            age  = 0;
         end
      end else begin
         age = 0;
      end
      rdy          = ready | (pop_on_done & done);
      mem_done_i   = done;
      mem_data_i   = done ? memWord(mem_addr_o) : 32'h0;
      jump_i       = jmp;
      jump_pc_i    = jpc;
      inst_ready_i = rdy;

      if (jmp) begin
         sb.delete();
         if (done) dropping = 1'b0;
         else if (mem_req_o) dropping = 1'b1;
         exp_pc = jpc;
      end else begin
         if (sb.size() != 0 && rdy) begin
            e = sb.pop_front();
            checkOutput("head_pc", pc_o, e.pc);
            checkOutput("head_inst", inst_o, e.inst);
         end
         if (done) begin
            if (dropping) begin
               dropping = 1'b0;
            end else begin
               e.pc   = exp_pc;
               e.inst = memWord(exp_pc);
               sb.push_back(e);
               exp_pc = exp_pc + 32'd4;
               push_count++;
            end
         end
      end
   endtask

   task automatic doReset();
      rst          = 1'b1;
      jump_i       = 1'b0;
      jump_pc_i    = 32'h0;
      mem_done_i   = 1'b0;
      mem_data_i   = 32'h0;
      inst_ready_i = 1'b0;
      sb.delete();
      exp_pc      = 32'h0;
      age         = 0;
      prev_req    = 1'b0;
      dropping    = 1'b0;
      req_count   = 0;
      push_count  = 0;
      pop_on_done = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_req", 32'(mem_req_o), 32'h0);
      checkOutput("rst_addr", mem_addr_o, 32'h0);
      checkOutput("rst_valid", 32'(inst_valid_o), 32'h0);
      checkOutput("rst_inst", inst_o, 32'h0);
      checkOutput("rst_pc", pc_o, 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      tests = 0;
      fails = 0;
      lat   = 2;
      ready = 1'b1;

      // Streaming fetch with decode always ready
      doReset();
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 32'h0);
      checkOutput("stream_reqs", 32'(req_count >= 4), 32'h1);

      // Decode stalled: queue fills to DEPTH, then one pop frees a slot
      ready = 1'b0;
      doReset();
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0);
      checkOutput("full_req_count", 32'(req_count), 32'd4);
      checkOutput("full_req_idle", 32'(mem_req_o), 32'h0);
      ready = 1'b1;
      applyStimulus(1'b0, 32'h0);
      ready = 1'b0;
      n = 0;
      while (req_count < 5 && n < 10) begin
         applyStimulus(1'b0, 32'h0);
         n++;
      end
      if (req_count < 5) timeoutFail("refill_req");

      // Redirect while waiting on 0x8; stale data returns three cycles later
      ready = 1'b1;
      doReset();
      n = 0;
      while (req_count < 3 && n < 30) begin
         applyStimulus(1'b0, 32'h0);
         n++;
      end
      if (req_count < 3) timeoutFail("req_0x8");
      lat = 5;
      applyStimulus(1'b1, 32'h100);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0);
      lat = 2;
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0);
      checkOutput("after_jump_reqs", 32'(req_count >= 5), 32'h1);

      // Redirect in the same cycle as the memory response
      ready = 1'b0;
      doReset();
      n = 0;
      while (req_count < 1 && n < 5) begin
         applyStimulus(1'b0, 32'h0);
         n++;
      end
      if (req_count < 1) timeoutFail("first_req");
      applyStimulus(1'b1, 32'h200);
      applyStimulus(1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0);
      checkOutput("jump_done_req", 32'(req_count), 32'd2);
      checkOutput("jump_done_addr", mem_addr_o, 32'h200);
      ready = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0);

      // Sustained push+pop at DEPTH-1 across several pointer wraps
      ready = 1'b0;
      doReset();
      n = 0;
      while (sb.size() < 3 && n < 40) begin
         applyStimulus(1'b0, 32'h0);
         n++;
      end
      if (sb.size() < 3) timeoutFail("fill_three");
      pop_on_done = 1'b1;
      n = push_count;
      for (int i = 0; i < 60 && push_count - n < 12; i++) applyStimulus(1'b0, 32'h0);
      if (push_count - n < 12) timeoutFail("wrap_pushes");
      pop_on_done = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0);

      // Asynchronous reset in the middle of a request
      lat = 10;
      doReset();
      n = 0;
      while (!mem_req_o && n < 5) begin
         applyStimulus(1'b0, 32'h0);
         n++;
      end
      if (!mem_req_o) timeoutFail("req_before_reset");
      applyStimulus(1'b0, 32'h0);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_req", 32'(mem_req_o), 32'h0);
      checkOutput("async_addr", mem_addr_o, 32'h0);
      checkOutput("async_valid", 32'(inst_valid_o), 32'h0);
      lat = 2;
      doReset();
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0);
      checkOutput("post_reset_reqs", 32'(req_count >= 2), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch stage with an internal prefetch queue. It replaces the single-shot combinational fetch. It owns the fetch PC and issues sequential word requests to the memory arbiter, holding one request outstanding at a time. It buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode through a valid/ready handshake. A jump/redirect flushes the queue and any in-flight fetch.

Parameters:
ADDR_WIDTH, 32, width of PCs and memory addresses
INST_WIDTH, 32, width of one instruction word
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, fetch PC after reset
PC_STEP, 4, fetch PC increment per instruction

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
jump_i  in  1  redirect request from execute; one-cycle pulse
jump_pc_i  in  ADDR_WIDTH  redirect target, valid when jump_i=1
mem_req_o  out  1  fetch request to memory arbiter, level-held until mem_done_i
mem_addr_o  out  ADDR_WIDTH  fetch address; stable while mem_req_o=1
mem_done_i  in  1  one-cycle pulse; mem_data_i is valid this cycle
mem_data_i  in  INST_WIDTH  returned instruction word
inst_valid_o  out  1  queue head is valid
inst_o  out  INST_WIDTH  queue head instruction; 0 when empty
pc_o  out  ADDR_WIDTH  queue head PC; 0 when empty
inst_ready_i  in  1  decode accepts the head this cycle (0 = stall)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, fetch_pc=RESET_PC, count=0, head/tail pointers=0.
  - mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, pc_o=0.
  - Reset mid-request abandons the request. Any mem_done_i seen after reset release while in IDLE is ignored.
- State machine (IDLE, WAIT, DROP):
  - IDLE:
    - If jump_i=1: load fetch_pc=jump_pc_i and stay in IDLE.
    - Else if count<DEPTH: latch mem_addr_o=fetch_pc, raise mem_req_o, go to WAIT.
    - Else (full): hold.
  - WAIT: mem_req_o=1, address held.
    - mem_done_i=1, jump_i=0: push {fetch_pc, mem_data_i}; fetch_pc+=PC_STEP; drop mem_req_o; go to IDLE.
    - mem_done_i=1, jump_i=1: discard data; fetch_pc=jump_pc_i; go to IDLE.
    - mem_done_i=0, jump_i=1: fetch_pc=jump_pc_i; go to DROP.
  - DROP: mem_req_o stays high with the old address until mem_done_i. Returned data is discarded, then go to IDLE.
    - A further jump_i while in DROP overwrites fetch_pc and stays in DROP.
- Request rule: at most one request outstanding. A request is issued only when count<DEPTH, so a push never meets a full queue.
- Minimum fetch rate: one instruction per 2 cycles plus memory latency. The IDLE bubble between requests is required.
- Queue:
  - inst_valid_o = (count!=0).
  - inst_o and pc_o are driven from the head entry registered storage. Both are 0 when count=0.
  - Pop when inst_valid_o & inst_ready_i & !jump_i.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Flush: jump_i=1 sets count=0 and pointers=0 in the same edge.
  - A same-cycle push and pop are suppressed.
  - inst_valid_o=0 from the next cycle.
- Arithmetic: fetch_pc increments modulo 2^ADDR_WIDTH and wraps silently. No alignment check.

Test Plan:
- Reset release, memory done 2 cycles after each request, inst_ready_i=1 → requests at 0x0, 0x4, 0x8 in order; decode sees pc_o=0x0, 0x4, 0x8 with matching data; no duplicates or gaps.
- inst_ready_i=0, DEPTH=4 → exactly 4 requests issued (0x0–0xC); mem_req_o stays 0 with count=4. Raise ready for 1 cycle → pop of 0x0, then a request for 0x10.
- jump_i with jump_pc_i=0x100 while in WAIT for 0x8, mem_done_i 3 cycles later with data 0xDEAD → data discarded; queue empty next cycle; next request is 0x100; first decoded pc_o=0x100.
- jump_i=1 in the same cycle as mem_done_i → no push; fetch_pc=jump target; request issued the following cycle.
- Simultaneous push and pop at count=DEPTH-1 → count stays DEPTH-1; order preserved across pointer wrap over 3×DEPTH instructions.
- rst asserted asynchronously mid-WAIT → all outputs 0 immediately; after release, first request is RESET_PC.
